dac_frame_scheduler: RTL and testbench

- Upstream feeder for the dual octal-DAC I2C master: owns the 16 per-channel 8-bit amplitude codes (DAC1 A..H, DAC2 A..H) and presents them as a stable, double-buffered word.
- Launches one full I2C refresh frame per programmable frame period by holding the master's enable level, then waits for done or error.
- Handles error retry, timeout, frame overrun and fault reporting, so stimulation firmware/control only writes codes and a commit strobe.

---
 rtl/dac_frame_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_dac_frame_scheduler.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_scheduler.sv
// Frame scheduler for the dual octal-DAC I2C master: double-buffered amplitude
// bank, periodic frame launch, retry/timeout handling and status counters.
module dac_frame_scheduler #(
    parameter int unsigned CLK_DIV_W = 16,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned GAP       = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 run,
    input  logic [CLK_DIV_W-1:0] frame_period,
    input  logic                 cfg_we,
    input  logic [3:0]           cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic                 cfg_ready,
    input  logic                 commit,
    output logic [127:0]         dac_data,
    output logic                 i2c_enable,
    input  logic                 i2c_done,
    input  logic                 i2c_error,
    output logic                 busy,
    output logic                 fault,
    output logic [15:0]          frame_count,
    output logic [7:0]           err_count,
    output logic [7:0]           overrun_count
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTick,
        StLaunch,
        StActive,
        StRetryGap,
        StFault
    } state_e;

    state_e               state_q, state_d;
    logic [127:0]         shadow_q, shadow_d;
    logic [127:0]         active_q, active_d;
    logic                 commit_pending_q, commit_pending_d;
    logic [CLK_DIV_W-1:0] count_q, count_d;
    logic [CLK_DIV_W-1:0] period_q, period_d;
    logic [TW-1:0]        to_q, to_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 enable_q, enable_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;
    logic [15:0]          frame_q, frame_d;
    logic [7:0]           err_q, err_d;
    logic [7:0]           ovr_q, ovr_d;

    logic [CLK_DIV_W-1:0] period_in;
    logic                 tick;
    logic                 busy_st;
    logic                 attempt_fail;
    logic                 leave_busy;

    assign period_in    = (frame_period < CLK_DIV_W'(2)) ? CLK_DIV_W'(2) : frame_period;
    assign tick         = run && (count_q == period_q - CLK_DIV_W'(1));
    assign busy_st      = (state_q == StLaunch) || (state_q == StActive) ||
                          (state_q == StRetryGap);
    assign attempt_fail = i2c_error || (to_q == TW'(TIMEOUT - 1));

    // Period counter; the period is re-sampled on every wrap and while held idle.
    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        if (!run || tick) begin
            count_d  = '0;
            period_d = period_in;
        end else begin
            count_d = count_q + CLK_DIV_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        to_d     = to_q;
        retry_d  = retry_q;
        gap_d    = gap_q;
        frame_d  = frame_q;
        err_d    = err_q;
        ovr_d    = ovr_q;

        if (tick && busy_st && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (run) state_d = StWaitTick;
            end
            StWaitTick: begin
                if (!run) begin
                    state_d = StIdle;
                end else if (tick) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                to_d    = '0;
                state_d = StActive;
            end
            StActive: begin
                to_d = to_q + TW'(1);
                // Error wins over a coincident done.
                if (attempt_fail) begin
                    if (err_q != 8'hFF) err_d = err_q + 8'd1;
                    if (!run) begin
                        state_d = StIdle;
                        retry_d = '0;
                    end else if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        gap_d   = '0;
                        state_d = StRetryGap;
                    end else begin
                        state_d = StFault;
                    end
                end else if (i2c_done) begin
                    frame_d = frame_q + 16'd1;
                    retry_d = '0;
                    state_d = run ? StWaitTick : StIdle;
                end
            end
            StRetryGap: begin
                if (gap_q == GW'(GAP - 1)) begin
                    state_d = StLaunch;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            StFault: begin
                if (!run) begin
                    state_d = StIdle;
                    retry_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        enable_d = (state_d == StActive);
        busy_d   = (state_d == StLaunch) || (state_d == StActive) || (state_d == StRetryGap);
        fault_d  = (state_d == StFault);
    end

    // Shadow/active banks: the active bank only moves outside a frame.
    always_comb begin
        shadow_d         = shadow_q;
        active_d         = active_q;
        commit_pending_d = commit_pending_q;
        leave_busy       = ((state_q == StActive) || (state_q == StRetryGap)) &&
                           ((state_d == StWaitTick) || (state_d == StIdle) ||
                            (state_d == StFault));

        if (cfg_we && !commit_pending_q) begin
            shadow_d[{cfg_addr, 3'b000} +: 8] = cfg_wdata;
        end

        if (!busy_st) begin
            if (commit) active_d = shadow_d;
        end else if (commit || commit_pending_q) begin
            if (leave_busy) begin
                active_d         = shadow_d;
                commit_pending_d = 1'b0;
            end else begin
                commit_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q          <= StIdle;
            shadow_q         <= '0;
            active_q         <= '0;
            commit_pending_q <= 1'b0;
            count_q          <= '0;
            period_q         <= CLK_DIV_W'(2);
            to_q             <= '0;
            retry_q          <= '0;
            gap_q            <= '0;
            enable_q         <= 1'b0;
            busy_q           <= 1'b0;
            fault_q          <= 1'b0;
            frame_q          <= '0;
            err_q            <= '0;
            ovr_q            <= '0;
        end else begin
            state_q          <= state_d;
            shadow_q         <= shadow_d;
            active_q         <= active_d;
            commit_pending_q <= commit_pending_d;
            count_q          <= count_d;
            period_q         <= period_d;
            to_q             <= to_d;
            retry_q          <= retry_d;
            gap_q            <= gap_d;
            enable_q         <= enable_d;
            busy_q           <= busy_d;
            fault_q          <= fault_d;
            frame_q          <= frame_d;
            err_q            <= err_d;
            ovr_q            <= ovr_d;
        end
    end

    assign cfg_ready     = !commit_pending_q;
    assign dac_data      = active_q;
    assign i2c_enable    = enable_q;
    assign busy          = busy_q;
    assign fault         = fault_q;
    assign frame_count   = frame_q;
    assign err_count     = err_q;
    assign overrun_count = ovr_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Scoreboard bench for dac_frame_scheduler: a tick-level model predicts every
// enable rise/fall with its data and counters; a monitor pops and compares.
`timescale 1ns/1ps
module tb_dac_frame_scheduler;

    localparam int GAPV = 4;
    localparam int MAXR = 3;
    localparam int TMO  = 4096;

    logic         clk = 1'b0;
    logic         resetn, run, cfg_we, commit, i2c_done, i2c_error;
    logic [15:0]  frame_period;
    logic [3:0]   cfg_addr;
    logic [7:0]   cfg_wdata;
    logic         cfg_ready, i2c_enable, busy, fault;
    logic [127:0] dac_data;
    logic [15:0]  frame_count;
    logic [7:0]   err_count, overrun_count;

    always #5 clk = ~clk;

    dac_frame_scheduler #(
        .CLK_DIV_W(16),
        .TIMEOUT  (TMO),
        .MAX_RETRY(MAXR),
        .GAP      (GAPV)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .run          (run),
        .frame_period (frame_period),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_ready    (cfg_ready),
        .commit       (commit),
        .dac_data     (dac_data),
        .i2c_enable   (i2c_enable),
        .i2c_done     (i2c_done),
        .i2c_error    (i2c_error),
        .busy         (busy),
        .fault        (fault),
        .frame_count  (frame_count),
        .err_count    (err_count),
        .overrun_count(overrun_count)
    );

    // kind: 0 done, 1 error, 2 done+error, 3 no response (timeout)
    typedef struct {int kind; int len;} att_t;
    typedef struct {int at; logic [127:0] data;} rise_t;
    typedef struct {int at; int frames; int errs; int ovr; logic flt;} fall_t;

    att_t  att_q[$];
    att_t  plan_q[$];
    rise_t rise_q[$];
    fall_t fall_q[$];

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int rises_seen = 0;
    int falls_seen = 0;

    logic [127:0] shadow_m, active_m;
    bit           pend_m;
    int           frames_m, errs_m, ovr_m;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int ticks_in(input int a, input int b, input int p);
        return (b + 1) / p - (a + 1) / p;
    endfunction

    // Tick-level reference: turns plan_q into expected enable rises and falls.
    task automatic plan(input int base, input int p, input bit last_open,
                        input logic [127:0] data);
        int start, prev, rise, fin, retries;
        att_t a;
        fall_t f;
        start   = p - 1;
        prev    = start;
        retries = 0;
        for (int i = 0; i < plan_q.size(); i++) begin
            a = plan_q[i];
            att_q.push_back(a);
            rise = start + 1;
            fin  = rise + ((a.kind == 3) ? TMO : a.len);
            rise_q.push_back('{at: base + rise, data: data});
            if (last_open && (i == plan_q.size() - 1)) break;
            ovr_m = ovr_m + ticks_in(prev, fin, p);
            if (ovr_m > 255) ovr_m = 255;
            if (a.kind == 0) begin
                frames_m++;
                retries = 0;
                start   = ((fin + 1) / p + 1) * p - 1;
                prev    = start;
                f = '{at: base + fin, frames: frames_m, errs: errs_m, ovr: ovr_m, flt: 1'b0};
                fall_q.push_back(f);
            end else begin
                if (errs_m < 255) errs_m++;
                f = '{at: base + fin, frames: frames_m, errs: errs_m, ovr: ovr_m, flt: 1'b0};
                if (retries < MAXR) begin
                    retries++;
                    start = fin + GAPV;
                    prev  = fin;
                    fall_q.push_back(f);
                end else begin
                    f.flt = 1'b1;
                    fall_q.push_back(f);
                    break;
                end
            end
        end
        plan_q.delete();
    endtask

    // I2C master model: answers each attempt per att_q.
    initial begin : master
        att_t cur;
        int   cnt;
        bit   have;
        have = 0;
        cnt  = 0;
        i2c_done  = 1'b0;
        i2c_error = 1'b0;
        forever begin
            @(negedge clk);
            if (i2c_enable && resetn) begin
                if (!have) begin
                    have = 1;
                    cnt  = 0;
                    if (att_q.size() > 0) cur = att_q.pop_front();
                    else cur = '{kind: 3, len: 0};
                end
                cnt++;
                i2c_done  = (cnt == cur.len) && (cur.kind == 0 || cur.kind == 2);
                i2c_error = (cnt == cur.len) && (cur.kind == 1 || cur.kind == 2);
            end else begin
                have      = 0;
                i2c_done  = 1'b0;
                i2c_error = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic en_prev, busy_prev;
        logic [127:0] data_prev;
        rise_t r;
        fall_t f;
        en_prev   = 1'b0;
        busy_prev = 1'b0;
        data_prev = '0;
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            if (resetn) begin
                if (busy && busy_prev) check("data_stable_busy", dac_data, data_prev);
                if (i2c_enable && !en_prev) begin
                    rises_seen++;
                    check("rise_expected", rise_q.size() != 0, 1'b1);
                    if (rise_q.size() != 0) begin
                        r = rise_q.pop_front();
                        check("rise_edge", edge_n, r.at);
                        check("rise_data", dac_data, r.data);
                    end
                end
                if (!i2c_enable && en_prev) begin
                    falls_seen++;
                    check("fall_expected", fall_q.size() != 0, 1'b1);
                    if (fall_q.size() != 0) begin
                        f = fall_q.pop_front();
                        check("fall_edge", edge_n, f.at);
                        check("fall_frame_count", frame_count, f.frames);
                        check("fall_err_count", err_count, f.errs);
                        check("fall_overrun_count", overrun_count, f.ovr);
                        check("fall_fault", fault, f.flt);
                    end
                end
            end
            en_prev   = i2c_enable & resetn;
            busy_prev = busy & resetn;
            data_prev = dac_data;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_dac_data"}, dac_data, '0);
        check({tag, "_enable"}, i2c_enable, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_fault"}, fault, 1'b0);
        check({tag, "_frame_count"}, frame_count, '0);
        check({tag, "_err_count"}, err_count, '0);
        check({tag, "_overrun_count"}, overrun_count, '0);
        check({tag, "_cfg_ready"}, cfg_ready, 1'b1);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        run    = 1'b0;
        cfg_we = 1'b0;
        commit = 1'b0;
        #1;
        check_reset_state("reset");
        repeat (3) @(negedge clk);
        rise_q.delete();
        fall_q.delete();
        att_q.delete();
        shadow_m = '0;
        active_m = '0;
        pend_m   = 0;
        frames_m = 0;
        errs_m   = 0;
        ovr_m    = 0;
        resetn   = 1'b1;
        @(negedge clk);
    endtask

    // Writes all 16 channels; the final write shares its cycle with commit.
    task automatic load_bank(input bit fixed);
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            d = fixed ? ((i == 15) ? 8'hFF : 8'((i + 1) * 17)) : 8'($urandom);
            cfg_we    = 1'b1;
            cfg_addr  = 4'(i);
            cfg_wdata = d;
            commit    = (i == 15);
            shadow_m[i*8 +: 8] = d;
            @(negedge clk);
        end
        cfg_we   = 1'b0;
        commit   = 1'b0;
        active_m = shadow_m;
        check("commit_idle_dac_data", dac_data, active_m);
    endtask

    task automatic cfg_write(input int a, input logic [7:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = 4'(a);
        cfg_wdata = d;
        if (!pend_m) shadow_m[a*8 +: 8] = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_run(input int fp, output int base);
        frame_period = 16'(fp);
        repeat (2) @(negedge clk);
        base = edge_n + 1;
        run  = 1'b1;
    endtask

    task automatic wait_falls(input int target, input int budget, input string name);
        int k = 0;
        while (falls_seen < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, falls_seen, target);
    endtask

    initial begin : main
        int base, p, len, f0, k;
        int fps[4];
        int lens[4];
        logic [7:0] old6;
        run = 1'b0; cfg_we = 1'b0; commit = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        frame_period = 16'd100;
        resetn = 1'b0;
        do_reset();

        // Three clean frames with the fixed code pattern.
        load_bank(1'b1);
        len = $urandom_range(20, 70);
        f0  = falls_seen;
        start_run(100, base);
        for (int i = 0; i < 3; i++) plan_q.push_back('{kind: 0, len: len});
        plan(base, 100, 1'b0, active_m);
        wait_falls(f0 + 3, 400, "s1_three_frames");
        run = 1'b0;
        check("s1_rises_consumed", rise_q.size(), 0);
        check("s1_frame_count", frame_count, 3);

        // Commit while a frame is in flight.
        f0   = falls_seen;
        old6 = active_m[55:48];
        start_run(100, base);
        plan_q.push_back('{kind: 0, len: 50});
        plan(base, 100, 1'b0, active_m);
        k = 0;
        while (!i2c_enable && k < 200) begin @(negedge clk); k++; end
        check("s2_active_reached", i2c_enable, 1'b1);
        cfg_write(5, 8'hA5);
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        pend_m = 1;
        check("s2_cfg_ready_pending", cfg_ready, 1'b0);
        cfg_write(6, 8'h5A);
        check("s2_dac_data_held", dac_data, active_m);
        wait_falls(f0 + 1, 200, "s2_frame_done");
        active_m = shadow_m;
        pend_m   = 0;
        check("s2_dac_data_after", dac_data, active_m);
        check("s2_ch5", dac_data[47:40], 8'hA5);
        check("s2_ch6_dropped", dac_data[55:48], old6);
        check("s2_cfg_ready", cfg_ready, 1'b1);
        run = 1'b0;

        // Every attempt errors; the last reports done and error together.
        do_reset();
        load_bank(1'b0);
        len = $urandom_range(5, 20);
        f0  = falls_seen;
        start_run(200, base);
        for (int i = 0; i < 3; i++) plan_q.push_back('{kind: 1, len: len});
        plan_q.push_back('{kind: 2, len: len});
        plan(base, 200, 1'b0, active_m);
        wait_falls(f0 + 4, 600, "s3_four_attempts");
        k = 0;
        while (edge_n < base + 420 && k < 600) begin @(negedge clk); k++; end
        check("s3_fault", fault, 1'b1);
        check("s3_err_count", err_count, errs_m);
        check("s3_overrun_in_fault", overrun_count, ovr_m);
        check("s3_frame_count", frame_count, 0);
        check("s3_enable_low", i2c_enable, 1'b0);
        run = 1'b0;
        repeat (2) @(negedge clk);
        check("s3_fault_cleared", fault, 1'b0);
        check("s3_idle_busy", busy, 1'b0);

        // Overrun: frames longer than the period, plus periods below 2.
        do_reset();
        fps  = '{20, 0, 1, 0};
        lens = '{50, 0, 3, 4};
        fps[1]  = $urandom_range(15, 25);
        lens[1] = $urandom_range(30, 60);
        for (int t = 0; t < 4; t++) begin
            p  = (fps[t] < 2) ? 2 : fps[t];
            f0 = falls_seen;
            start_run(fps[t], base);
            for (int i = 0; i < 2; i++) plan_q.push_back('{kind: 0, len: lens[t]});
            plan(base, p, 1'b0, active_m);
            wait_falls(f0 + 2, 400, "s4_overrun_frames");
            run = 1'b0;
        end
        check("s4_overrun_total", overrun_count, ovr_m);

        // Master silent: timeout, retry, then reset during the retry.
        do_reset();
        load_bank(1'b0);
        f0 = falls_seen;
        k  = rises_seen;
        start_run(5000, base);
        plan_q.push_back('{kind: 3, len: 0});
        plan_q.push_back('{kind: 3, len: 0});
        plan(base, 5000, 1'b1, active_m);
        wait_falls(f0 + 1, 9300, "s5_timeout");
        f0 = 0;
        while (rises_seen < k + 2 && f0 < 50) begin @(negedge clk); f0++; end
        check("s5_retry_rise", rises_seen, k + 2);
        repeat (10) @(negedge clk);
        check("s5_active_before_reset", i2c_enable, 1'b1);
        check("s5_rises_consumed", rise_q.size(), 0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
